// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Brief   : Shared 800x600 timing constants and arbiter state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_hact = 800;
    localparam int c_vact = 600;
    localparam int c_htot = 1056;
    localparam int c_vtot = 628;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DISP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick: first requester at/after ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : vga_mem_arbiter
// Brief   : Frame-RAM sharing between display fetch (active area) and
//           round-robin pixel writers (blanking).
// Revision: 1.0 - initial release
// ============================================================================
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int AW    = 19,
    parameter int DW    = 12,
    parameter int HACT  = c_hact,
    parameter int VACT  = c_vact,
    parameter int HTOT  = c_htot,
    parameter int VTOT  = c_vtot,
    parameter int BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          hcount,
    input  logic [10:0]          vcount,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic [DW-1:0]        pix_rgb,
    output logic                 pix_valid
);

    localparam int              c_pw      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int              c_cw      = $clog2(BURST + 1);
    localparam logic [10:0]     c_hact11  = 11'(HACT);
    localparam logic [10:0]     c_vact11  = 11'(VACT);
    localparam logic [10:0]     c_hlast   = 11'(HTOT - 1);
    localparam logic [10:0]     c_vlast   = 11'(VTOT - 1);
    localparam logic [AW-1:0]   c_hact_aw = AW'(HACT);
    localparam logic [c_pw-1:0] c_plast   = c_pw'(NREQ - 1);
    localparam logic [c_cw-1:0] c_burst   = c_cw'(BURST);

    state_t          r_state;
    logic [NREQ-1:0] r_gnt;
    logic [c_pw-1:0] r_ptr;
    logic [c_cw-1:0] r_cnt;
    logic            r_act_d;
    logic [DW-1:0]   r_pix_rgb;
    logic            r_pix_valid;

    logic            w_active;
    logic            w_nxt_active;
    logic            w_h_last;
    logic [10:0]     w_h_nxt;
    logic [10:0]     w_v_nxt;
    logic [AW-1:0]   w_fetch_addr;
    logic [NREQ-1:0] w_arb_gnt;
    logic [c_pw-1:0] w_gidx;
    logic [AW-1:0]   w_wr_addr;
    logic [DW-1:0]   w_wr_data;
    logic            w_fire;
    logic [c_cw-1:0] w_cnt_nxt;

    assign w_active     = (hcount < c_hact11) && (vcount < c_vact11);
    assign w_h_last     = (hcount == c_hlast);
    assign w_h_nxt      = w_h_last ? 11'd0 : hcount + 11'd1;
    assign w_v_nxt      = !w_h_last ? vcount :
                          ((vcount == c_vlast) ? 11'd0 : vcount + 11'd1);
    assign w_nxt_active = (w_h_nxt < c_hact11) && (w_v_nxt < c_vact11);
    assign w_fetch_addr = AW'(vcount) * c_hact_aw + AW'(hcount);

    assign w_fire    = |(req & r_gnt);
    assign w_cnt_nxt = r_cnt + c_cw'(w_fire);

    rr_arbiter #(
        .N  (NREQ),
        .PW (c_pw)
    ) u_rr_arbiter (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_arb_gnt)
    );

    // Grant is one-hot, so an OR-reduce over the granted slice is the mux.
    always_comb begin
        w_gidx    = '0;
        w_wr_addr = '0;
        w_wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_gidx    = w_gidx | c_pw'(i);
                w_wr_addr = w_wr_addr | req_addr[i*AW +: AW];
                w_wr_data = w_wr_data | req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_nxt_active) begin
                        r_state <= ST_DISP;
                    end else if (|req) begin
                        r_state <= ST_WRITE;
                        r_gnt   <= w_arb_gnt;
                        r_cnt   <= '0;
                    end
                end
                ST_WRITE: begin
                    r_cnt <= w_cnt_nxt;
                    // Release one cycle ahead of the active area so the
                    // fetch never shares a cycle with a write.
                    if (w_nxt_active || !w_fire || (w_cnt_nxt == c_burst)) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_ptr   <= (w_gidx == c_plast) ? '0 : w_gidx + 1'b1;
                    end
                end
                ST_DISP: begin
                    if (!w_nxt_active) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    // pix_rgb lags mem_rdata by one register stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_act_d     <= 1'b0;
            r_pix_rgb   <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_act_d     <= w_active;
            r_pix_rgb   <= r_act_d ? mem_rdata : '0;
            r_pix_valid <= r_act_d;
        end
    end

    // Reset blocks both the fetch and any in-flight write in the same cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst) begin
            if (w_active) begin
                mem_en   = 1'b1;
                mem_addr = w_fetch_addr;
            end else if (w_fire) begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_wr_addr;
                mem_wdata = w_wr_data;
            end
        end
    end

    assign gnt       = r_gnt & {NREQ{rst}};
    assign pix_rgb   = r_pix_rgb;
    assign pix_valid = r_pix_valid;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_mem_arbiter
// Brief   : Directed bench for vga_mem_arbiter (BURST=16 and BURST=2 copies).
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 19;
    localparam int DW   = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [10:0]      hcount;
    logic [10:0]      vcount;
    logic [NREQ-1:0]  req;
    logic [AW-1:0]    wa0, wa1, wa2, wa3;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;

    logic [NREQ-1:0]  gnt1;
    logic             mem_en, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;
    logic [DW-1:0]    pix_rgb;
    logic             pix_valid;

    logic [NREQ-1:0]  gnt2;
    logic             mem_en2, mem_we2;
    logic [AW-1:0]    mem_addr2;
    logic [DW-1:0]    mem_wdata2;
    logic [DW-1:0]    pix_rgb2;
    logic             pix_valid2;
    logic [DW-1:0]    zero_rdata = '0;

    logic [DW-1:0]    mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int wr_bad = 0;
    int wr_act = 0;
    int gnt_act = 0;
    int base;
    logic wmodel = 1'b0;
    logic [NREQ-1:0] fire;
    logic tb_active;
    logic [3:0] rr_exp [0:11];

    always #5 clk = ~clk;

    assign req_addr  = {wa3, wa2, wa1, wa0};
    assign req_wdata = {wa3[11:0] + 12'h0A0, wa2[11:0] + 12'h0A0,
                        wa1[11:0] + 12'h0A0, wa0[11:0] + 12'h0A0};
    assign tb_active = (hcount < 11'd800) && (vcount < 11'd600);

    vga_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST(16)) u_dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt1), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_rgb(pix_rgb), .pix_valid(pix_valid)
    );

    vga_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST(2)) u_dut_b2 (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt2), .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(zero_rdata),
        .pix_rgb(pix_rgb2), .pix_valid(pix_valid2)
    );

    // Frame RAM with 1-cycle read latency; two pixels preloaded under reset.
    always @(posedge clk) begin
        if (!rst) begin
            mem[1605] <= 12'hABC;
            mem[1606] <= 12'h123;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (rst && mem_en && mem_we) begin
            wr_cnt++;
            if (mem_wdata !== mem_addr[11:0] + 12'h0A0) wr_bad++;
            if (tb_active) wr_act++;
        end
        if (tb_active && (gnt1 != '0 || gnt2 != '0)) gnt_act++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and present position (nh,nv) for the new cycle.
    task automatic step(input int nh, input int nv);
        fire = req & gnt1;
        @(posedge clk);
        #1;
        hcount = 11'(nh);
        vcount = 11'(nv);
        if (wmodel && fire[1]) begin
            wa1 = wa1 + 1'b1;
            if (wa1 == 19'd120) req[1] = 1'b0;
        end
        #1;
    endtask

    initial begin
        rr_exp = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                   4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};
        rst = 1'b0; hcount = 11'd300; vcount = 11'd100; req = '0;
        wa0 = 19'd1000; wa1 = 19'd2000; wa2 = 19'd3000; wa3 = 19'd4000;

        // Reset held three cycles mid-frame
        step(300, 100); step(300, 100); step(300, 100);
        chk("rst_gnt", 32'(gnt1), 32'h0);
        chk("rst_gnt_b2", 32'(gnt2), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_pix_rgb", 32'(pix_rgb), 32'h0);
        chk("rst_pix_valid", 32'(pix_valid), 32'h0);

        step(0, 0); rst = 1'b1; #1;
        chk("first_fetch_en", 32'(mem_en), 32'h1);
        chk("first_fetch_we", 32'(mem_we), 32'h0);
        chk("first_fetch_addr", 32'(mem_addr), 32'h0);

        // Display fetch and pixel pipe
        step(5, 2);
        chk("fetch_addr_5_2", 32'(mem_addr), 32'd1605);
        chk("fetch_we_5_2", 32'(mem_we), 32'h0);
        step(6, 2);
        chk("fetch_addr_6_2", 32'(mem_addr), 32'd1606);
        step(7, 2);
        chk("pix_rgb_1605", 32'(pix_rgb), 32'hABC);
        chk("pix_valid_1605", 32'(pix_valid), 32'h1);
        step(8, 2);
        chk("pix_rgb_1606", 32'(pix_rgb), 32'h123);
        step(799, 2); step(800, 2); step(801, 2); step(802, 2);
        chk("pix_rgb_blank", 32'(pix_rgb), 32'h0);
        chk("pix_valid_blank", 32'(pix_valid), 32'h0);
        chk("blank_mem_en", 32'(mem_en), 32'h0);

        // Round-robin on the BURST=2 copy
        step(849, 30); step(850, 30);
        req = 4'b1011; #1;
        chk("rr_before", 32'(gnt2), 32'h0);
        for (int k = 0; k < 12; k++) begin
            step(851 + k, 30);
            chk($sformatf("rr_gnt_h%0d", 851 + k), 32'(gnt2), 32'(rr_exp[k]));
        end
        req = '0; #1;
        step(863, 30); step(864, 30); step(865, 30);

        // Single writer 1: 16-word burst then re-grant for the last 4
        wa1 = 19'd100; wmodel = 1'b1;
        step(799, 10); step(800, 10);
        req = 4'b0010; #1;
        chk("sw_gnt_h800", 32'(gnt1), 32'h0);
        base = wr_cnt;
        step(801, 10);
        chk("sw_gnt_h801", 32'(gnt1), 32'h2);
        chk("sw_we_h801", 32'(mem_we), 32'h1);
        chk("sw_addr_h801", 32'(mem_addr), 32'd100);
        chk("sw_wdata_h801", 32'(mem_wdata), 32'h104);
        for (int h = 802; h <= 816; h++) step(h, 10);
        step(817, 10);
        chk("sw_gnt_h817", 32'(gnt1), 32'h0);
        step(818, 10);
        chk("sw_gnt_h818", 32'(gnt1), 32'h2);
        chk("sw_addr_h818", 32'(mem_addr), 32'd116);
        for (int h = 819; h <= 821; h++) step(h, 10);
        step(822, 10);
        chk("sw_drop_req", 32'(req[1]), 32'h0);
        chk("sw_drop_we", 32'(mem_we), 32'h0);
        step(823, 10);
        chk("sw_gnt_h823", 32'(gnt1), 32'h0);
        step(824, 10);
        chk("sw_word_count", 32'(wr_cnt - base), 32'd20);
        chk("sw_mem100", 32'(mem[100]), 32'h104);
        chk("sw_mem119", 32'(mem[119]), 32'h117);
        wmodel = 1'b0;

        // Blank-end cutoff: grant at HTOT-3, released before h=0
        step(1050, 50); step(1051, 50); step(1052, 50);
        req = 4'b0100; #1;
        step(1053, 50);
        chk("cut_gnt_1053", 32'(gnt1), 32'h4);
        chk("cut_we_1053", 32'(mem_we), 32'h1);
        step(1054, 50);
        step(1055, 50);
        chk("cut_gnt_1055", 32'(gnt1), 32'h4);
        step(0, 51);
        chk("cut_gnt_0", 32'(gnt1), 32'h0);
        chk("cut_we_0", 32'(mem_we), 32'h0);
        chk("cut_en_0", 32'(mem_en), 32'h1);
        chk("cut_addr_0_51", 32'(mem_addr), 32'd40800);
        step(1, 51); step(2, 51);
        chk("cut_gnt_2", 32'(gnt1), 32'h0);
        req = '0; #1;

        // Reset on the fifth word of a writer-3 burst
        step(899, 60); step(900, 60);
        req = 4'b1000; #1;
        step(901, 60);
        chk("mb_gnt_901", 32'(gnt1), 32'h8);
        step(902, 60); step(903, 60); step(904, 60); step(905, 60);
        rst = 1'b0; #1;
        chk("mb_rst_gnt", 32'(gnt1), 32'h0);
        chk("mb_rst_we", 32'(mem_we), 32'h0);
        chk("mb_rst_en", 32'(mem_en), 32'h0);
        step(906, 60);
        rst = 1'b1; req = 4'b1001; #1;
        chk("mb_gnt_906", 32'(gnt1), 32'h0);
        step(907, 60);
        chk("mb_gnt_907", 32'(gnt1), 32'h1);
        req = '0; #1;
        step(908, 60); step(909, 60);

        chk("no_write_active", 32'(wr_act), 32'h0);
        chk("no_gnt_active", 32'(gnt_act), 32'h0);
        chk("write_data_match", 32'(wr_bad), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
